alu_op_scheduler: RTL and testbench
===================================

// Module: alu_op_scheduler
// PURPOSE
//  Sequences the SPI-fed ALU datapath: queues 24-bit commands captured from the SPI controller and issues them one at a time.
//  Per command: load source register, start ALU, wait for ALU result, write result into destination register file.
//  Adds queueing, an ALU response timeout, sticky error flags and a completed-op counter.
//  Command format: [21:19] dest addr, [18:16] ALU sel, [15:8] operand a, [7:0] operand b; bits [23:22] ignored.
// PARAMETERS
//  DEPTH    4   command FIFO entries (power of 2, >=2)
//  TIMEOUT  15  max WAIT cycles for alu_done before op is abandoned (>=1)
//  CNT_W    16  width of done_cnt
// PORTS
//  clk         in   1              single clock, all logic on rising edge
//  rst         in   1              synchronous, active-high reset
//  cmd_valid   in   1              command strobe from SPI controller (1 cycle per command)
//  cmd_data    in   24             command word
//  cmd_ready   out  1              FIFO not full
//  src_cap_en  out  1              source register capture enable
//  src_data    out  24             word driven to source register (FIFO head while LOAD)
//  alu_en      out  1              ALU start strobe
//  alu_done    in   1              ALU result valid (ALU out_en)
//  alu_result  in   8              ALU result
//  dst_cap_en  out  1              destination register write enable
//  dst_addr    out  3              destination register index
//  dst_wdata   out  8              destination write data
//  busy        out  1              state != IDLE or FIFO non-empty
//  err_timeout out  1              sticky: an op timed out
//  err_ovf     out  1              sticky: cmd_valid while full (command dropped)
//  fifo_count  out  $clog2(DEPTH)+1 entries queued
//  done_cnt    out  CNT_W          ops written to destination; wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: FIFO emptied, state IDLE, wait counter 0; all outputs 0 except cmd_ready=1. Reset mid-op abandons it, no write.
//  FIFO: push on cmd_valid && cmd_ready; cmd_ready = !full (a same-cycle pop does not free a slot for that push).
//   cmd_valid && full: command dropped, err_ovf<=1. Pop happens at end of LOAD. Pointers wrap modulo DEPTH.
//  FSM (registered state, Moore outputs):
//   IDLE : fifo_count!=0 -> LOAD, else stay.
//   LOAD : src_cap_en=1, src_data=head; head's addr latched internally; pop; -> START.
//   START: alu_en=1 for exactly 1 cycle; wait counter cleared; -> WAIT.
//   WAIT : alu_done=1 -> latch alu_result, -> WRITE. Else counter++; reaching TIMEOUT without done -> err_timeout<=1, -> IDLE, no write.
//   WRITE: dst_cap_en=1, dst_addr=latched addr, dst_wdata=latched result; done_cnt++; -> LOAD if FIFO non-empty, else IDLE.
//  alu_done outside WAIT is ignored. src_data=0 outside LOAD; dst_addr/dst_wdata=0 outside WRITE.
//  Latency: push at edge E0 into empty FIFO, idle FSM -> LOAD E1-E2, START E2-E3, WAIT from E3;
//   done in first WAIT cycle -> WRITE E4-E5 (result stored at E5). Back-to-back ops: 4 cycles + ALU wait each.
//  Ops complete strictly in FIFO order. A timed-out op is lost. Next FIFO entry proceeds normally.
//  Error flags clear only on rst. done_cnt counts WRITE cycles only.
// TESTING
//  1. Reset, push 0x0A0305 (addr1 sel2 a=3 b=5), done 1 cycle after alu_en, result 0x08 -> one LOAD/START pulse each; dst_cap_en 1 cycle, addr=1, wdata=0x08; done_cnt=1.
//  2. Push 4 cmds back-to-back (DEPTH=4) -> cmd_ready low after 4th; 5th push sets err_ovf; 4 writes in push order, done_cnt=4.
//  3. Never assert alu_done -> err_timeout=1 after TIMEOUT WAIT cycles; no dst_cap_en; next queued cmd still completes.
//  4. Spurious alu_done in IDLE/LOAD/START -> no write, state unchanged, done_cnt unchanged.
//  5. rst asserted during WAIT with 2 queued -> next cycle: IDLE, fifo_count=0, all outputs 0; late alu_done ignored.
//  6. CNT_W=2, run 5 ops -> done_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_op_scheduler_if.sv
// Bundles the command, ALU and destination-register signals of alu_op_scheduler.
// master = SPI controller / ALU / register file side, slave = the scheduler.
interface alu_op_scheduler_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic [23:0]       cmd_data;
  logic              cmd_ready;
  logic              src_cap_en;
  logic [23:0]       src_data;
  logic              alu_en;
  logic              alu_done;
  logic [7:0]        alu_result;
  logic              dst_cap_en;
  logic [2:0]        dst_addr;
  logic [7:0]        dst_wdata;
  logic              busy;
  logic              err_timeout;
  logic              err_ovf;
  logic [CW-1:0]     fifo_count;
  logic [CNT_W-1:0]  done_cnt;

  modport master (
    output cmd_valid, cmd_data, alu_done, alu_result,
    input  cmd_ready, src_cap_en, src_data, alu_en, dst_cap_en, dst_addr,
           dst_wdata, busy, err_timeout, err_ovf, fifo_count, done_cnt
  );

  modport slave (
    input  cmd_valid, cmd_data, alu_done, alu_result,
    output cmd_ready, src_cap_en, src_data, alu_en, dst_cap_en, dst_addr,
           dst_wdata, busy, err_timeout, err_ovf, fifo_count, done_cnt
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Queues 24-bit SPI commands and issues them one at a time to the ALU:
// load source register, start ALU, wait for result (with timeout), write destination.
module alu_op_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_scheduler_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [1:0] rsvd;
    logic [2:0] dst;
    logic [2:0] sel;
    logic [7:0] opa;
    logic [7:0] opb;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  cmd_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     wcnt_q, wcnt_d;
  logic [2:0]        addr_q, addr_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              src_cap_en_q, src_cap_en_d;
  logic [23:0]       src_data_q, src_data_d;
  logic              alu_en_q, alu_en_d;
  logic              dst_cap_en_q, dst_cap_en_d;
  logic [2:0]        dst_addr_q, dst_addr_d;
  logic [7:0]        dst_wdata_q, dst_wdata_d;
  logic              busy_q, busy_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_ovf_q, err_ovf_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

  logic              full;
  logic              push;
  logic              pop;
  cmd_t              head;

  assign full = (count_q == CW'(DEPTH));
  assign push = bus.cmd_valid && !full;
  assign pop  = (state_q == S_LOAD);
  assign head = mem_q[rd_ptr_q];

  // FIFO storage has no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_t'(bus.cmd_data);
    end
  end

  // Next-state, FIFO bookkeeping and registered-output computation
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    wcnt_d        = wcnt_q;
    addr_d        = addr_q;
    err_timeout_d = err_timeout_q;
    err_ovf_d     = err_ovf_q;
    done_cnt_d    = done_cnt_q;
    dst_wdata_d   = '0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (bus.cmd_valid && full) begin
      err_ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        addr_d  = head.dst;
        state_d = S_START;
      end
      S_START: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.alu_done) begin
          dst_wdata_d = bus.alu_result;
          state_d     = S_WRITE;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
          if (wcnt_d == TW'(TIMEOUT)) begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        done_cnt_d = done_cnt_q + CNT_W'(1);
        state_d    = (count_q != '0) ? S_LOAD : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Moore outputs are registered, so they are derived from the next state
    cmd_ready_d  = (count_d != CW'(DEPTH));
    src_cap_en_d = (state_d == S_LOAD);
    src_data_d   = (state_d == S_LOAD) ? 24'(head) : 24'd0;
    alu_en_d     = (state_d == S_START);
    dst_cap_en_d = (state_d == S_WRITE);
    dst_addr_d   = (state_d == S_WRITE) ? addr_q : 3'd0;
    busy_d       = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wcnt_q        <= '0;
      addr_q        <= '0;
      cmd_ready_q   <= 1'b1;
      src_cap_en_q  <= 1'b0;
      src_data_q    <= '0;
      alu_en_q      <= 1'b0;
      dst_cap_en_q  <= 1'b0;
      dst_addr_q    <= '0;
      dst_wdata_q   <= '0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      done_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wcnt_q        <= wcnt_d;
      addr_q        <= addr_d;
      cmd_ready_q   <= cmd_ready_d;
      src_cap_en_q  <= src_cap_en_d;
      src_data_q    <= src_data_d;
      alu_en_q      <= alu_en_d;
      dst_cap_en_q  <= dst_cap_en_d;
      dst_addr_q    <= dst_addr_d;
      dst_wdata_q   <= dst_wdata_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
      err_ovf_q     <= err_ovf_d;
      done_cnt_q    <= done_cnt_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.src_cap_en  = src_cap_en_q;
  assign bus.src_data    = src_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.dst_cap_en  = dst_cap_en_q;
  assign bus.dst_addr    = dst_addr_q;
  assign bus.dst_wdata   = dst_wdata_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_ovf     = err_ovf_q;
  assign bus.fifo_count  = count_q;
  assign bus.done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based reference model; a second instance uses a 2-bit done counter.
module tb_alu_op_scheduler;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  alu_op_scheduler_if #(.DEPTH(DEPTH), .CNT_W(16)) bif ();
  alu_op_scheduler_if #(.DEPTH(DEPTH), .CNT_W(2))  bif2 ();

  alu_op_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  alu_op_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(2)) dut_w2 (
    .clk (clk),
    .rst (rst),
    .bus (bif2.slave)
  );

  assign bif2.cmd_valid  = bif.cmd_valid;
  assign bif2.cmd_data   = bif.cmd_data;
  assign bif2.alu_done   = bif.alu_done;
  assign bif2.alu_result = bif.alu_result;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a command queue plus the op in flight, tracked as
  // "cycles since this op was loaded" (0 = load, 1 = start, >=2 = waiting on ALU).
  logic [23:0] m_q[$];
  bit          m_valid = 1'b0;
  bit          m_act   = 1'b0;
  bit          m_wr    = 1'b0;
  bit          m_eto   = 1'b0;
  bit          m_eovf  = 1'b0;
  int          m_age   = 0;
  int unsigned m_nd    = 0;
  logic [7:0]  m_res   = '0;
  logic [23:0] m_cur   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_act = 1'b0; m_wr = 1'b0; m_age = 0; m_nd = 0;
      m_eto = 1'b0; m_eovf = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      automatic int n0   = m_q.size();
      automatic bit push = bif.cmd_valid && (n0 < DEPTH);
      automatic bit go   = 1'b0;
      if (bif.cmd_valid && (n0 >= DEPTH)) m_eovf = 1'b1;
      if (m_wr) begin
        m_wr = 1'b0;
        m_nd++;
        go = (n0 != 0);
      end else if (!m_act) begin
        go = (n0 != 0);
      end else if (m_age == 0) begin
        m_cur = m_q.pop_front();
        m_age = 1;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (bif.alu_done) begin
        m_act = 1'b0;
        m_wr  = 1'b1;
        m_res = bif.alu_result;
      end else if (m_age - 1 >= int'(TIMEOUT)) begin
        m_act = 1'b0;
        m_eto = 1'b1;
      end else begin
        m_age++;
      end
      if (go) begin
        m_act = 1'b1;
        m_age = 0;
      end
      if (push) m_q.push_back(bif.cmd_data);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      automatic bit          ld = m_act && (m_age == 0);
      automatic logic [23:0] hd = (m_q.size() != 0) ? m_q[0] : 24'd0;
      automatic logic [23:0] cw = m_cur;
      chk("cmd_ready",   32'(bif.cmd_ready),   32'(m_q.size() < DEPTH));
      chk("fifo_count",  32'(bif.fifo_count),  32'(m_q.size()));
      chk("src_cap_en",  32'(bif.src_cap_en),  32'(ld));
      chk("src_data",    32'(bif.src_data),    ld ? 32'(hd) : 32'd0);
      chk("alu_en",      32'(bif.alu_en),      32'(m_act && (m_age == 1)));
      chk("dst_cap_en",  32'(bif.dst_cap_en),  32'(m_wr));
      chk("dst_addr",    32'(bif.dst_addr),    m_wr ? 32'(cw[21:19]) : 32'd0);
      chk("dst_wdata",   32'(bif.dst_wdata),   m_wr ? 32'(m_res) : 32'd0);
      chk("busy",        32'(bif.busy),        32'(m_act || m_wr || (m_q.size() != 0)));
      chk("err_timeout", 32'(bif.err_timeout), 32'(m_eto));
      chk("err_ovf",     32'(bif.err_ovf),     32'(m_eovf));
      chk("done_cnt",    32'(bif.done_cnt),    m_nd % 65536);
      chk("done_cnt_w2", 32'(bif2.done_cnt),   m_nd % 4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pv [6] = '{20, 70, 10, 50, 90, 30};
  int pd [6] = '{40, 30,  0,  5, 60, 20};

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bif.cmd_valid  = 1'b0;
    bif.cmd_data   = '0;
    bif.alu_done   = 1'b0;
    bif.alu_result = '0;
    step();
    step();
    chk("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    chk("rst_busy",      32'(bif.busy),      32'd0);
    chk("rst_count",     32'(bif.fifo_count), 32'd0);
    rst = 1'b0;

    // Single op: addr 1, result 0x08, done one cycle after alu_en
    bif.cmd_valid = 1'b1;
    bif.cmd_data  = 24'h0A0305;
    step();
    bif.cmd_valid = 1'b0;
    chk("t1_count1",   32'(bif.fifo_count), 32'd1);
    step();
    chk("t1_load",     32'(bif.src_cap_en), 32'd1);
    chk("t1_src_data", 32'(bif.src_data),   32'h0A0305);
    step();
    chk("t1_start",    32'(bif.alu_en),     32'd1);
    chk("t1_count0",   32'(bif.fifo_count), 32'd0);
    step();
    chk("t1_alu_en_1cyc", 32'(bif.alu_en),  32'd0);
    bif.alu_done   = 1'b1;
    bif.alu_result = 8'h08;
    step();
    bif.alu_done = 1'b0;
    chk("t1_write",    32'(bif.dst_cap_en), 32'd1);
    chk("t1_addr",     32'(bif.dst_addr),   32'd1);
    chk("t1_wdata",    32'(bif.dst_wdata),  32'h08);
    step();
    chk("t1_write_1cyc", 32'(bif.dst_cap_en), 32'd0);
    chk("t1_done_cnt", 32'(bif.done_cnt),   32'd1);
    chk("t1_idle",     32'(bif.busy),       32'd0);

    // Spurious alu_done while idle
    bif.alu_done = 1'b1;
    repeat (3) step();
    bif.alu_done = 1'b0;
    chk("t4_no_write", 32'(bif.dst_cap_en), 32'd0);
    chk("t4_done_cnt", 32'(bif.done_cnt),   32'd1);

    // Six back-to-back pushes fill the FIFO and overflow; first op times out
    for (int i = 0; i < 6; i++) begin
      bif.cmd_valid = 1'b1;
      bif.cmd_data  = {2'b00, 3'(i + 2), 3'd0, 8'(i), 8'(i)};
      step();
      if (i == 4) begin
        chk("t2_full_count", 32'(bif.fifo_count), 32'd4);
        chk("t2_not_ready",  32'(bif.cmd_ready),  32'd0);
        chk("t2_no_ovf_yet", 32'(bif.err_ovf),    32'd0);
      end
      if (i == 5) chk("t2_ovf", 32'(bif.err_ovf), 32'd1);
    end
    bif.cmd_valid = 1'b0;
    repeat (12) step();
    chk("t3_not_yet_timeout", 32'(bif.err_timeout), 32'd0);
    step();
    chk("t3_timeout",  32'(bif.err_timeout), 32'd1);
    chk("t3_no_count", 32'(bif.done_cnt),    32'd1);
    bif.alu_done = 1'b1;
    repeat (40) begin
      bif.alu_result = 8'($urandom);
      step();
    end
    bif.alu_done = 1'b0;
    chk("t2_done_cnt",    32'(bif.done_cnt),   32'd5);
    chk("t6_done_cnt_w2", 32'(bif2.done_cnt),  32'd1);
    chk("t2_drained",     32'(bif.busy),       32'd0);

    // Reset while waiting on the ALU with two commands queued
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bif.cmd_valid = 1'b1;
      bif.cmd_data  = 24'($urandom);
      step();
    end
    bif.cmd_valid = 1'b0;
    step();
    chk("t5_queued", 32'(bif.fifo_count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bif.alu_done = 1'b1;
    chk("t5_count0", 32'(bif.fifo_count), 32'd0);
    chk("t5_busy0",  32'(bif.busy),       32'd0);
    chk("t5_ready1", 32'(bif.cmd_ready),  32'd1);
    step();
    bif.alu_done = 1'b0;
    chk("t5_late_done_ignored", 32'(bif.dst_cap_en), 32'd0);
    chk("t5_done_cnt0",         32'(bif.done_cnt),   32'd0);

    // Randomized traffic with varying push and ALU-response rates, occasional resets
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 500; c++) begin
        rst            = ($urandom_range(0, 249) == 0);
        bif.cmd_valid  = ($urandom_range(0, 99) < pv[s]);
        bif.cmd_data   = 24'($urandom);
        bif.alu_done   = ($urandom_range(0, 99) < pd[s]);
        bif.alu_result = 8'($urandom);
        step();
      end
    end
    rst = 1'b0;
    bif.cmd_valid = 1'b0;
    bif.alu_done  = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
